// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared defaults and types for the regfile write-port arbiter
package regfile_arb_pkg;

  localparam int N_REQ_DEF     = 3;
  localparam int ADDR_W_DEF    = 3;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic {
    ST_IDLE,
    ST_OWN
  } arb_state_e;

  typedef logic [$clog2(N_REQ_DEF)-1:0] grant_idx_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first request at or after rr_ptr
module rr_pick #(
  parameter int N_REQ = regfile_arb_pkg::N_REQ_DEF,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  int pos;

  // Scan from the farthest slot back toward rr_ptr so the nearest request wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    pos = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = int'(rr_ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (req[pos]) begin
        gnt      = '0;
        gnt[pos] = 1'b1;
        idx      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin write-port arbiter with burst ownership for the regfile
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_last,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rf_wr_en,
  output logic [ADDR_W-1:0]         rf_wr_addr,
  output logic [DATA_W-1:0]         rf_wr_data,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      owned
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] beat_cnt;
  logic [IDX_W-1:0] rr_ptr;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] ptr_next;
  logic [CNT_W-1:0] cnt_next;
  logic             xfer;
  logic             sel_last;
  logic             release_now;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .gnt    (pick_gnt),
    .idx    (pick_idx)
  );

  always_comb begin
    req_ready = '0;
    sel_idx   = pick_idx;
    if (state == ST_OWN) begin
      sel_idx          = owner;
      req_ready[owner] = req_valid[owner];
    end else begin
      req_ready = pick_gnt;
    end
    if (!rst_n) req_ready = '0;
  end

  assign xfer        = |req_ready;
  assign sel_last    = req_last[sel_idx];
  assign cnt_next    = ((state == ST_OWN) ? beat_cnt : '0) + CNT_W'(1);
  // Hitting MAX_BURST hands the port back even without last; the rest re-arbitrates.
  assign release_now = sel_last || (cnt_next == CNT_W'(MAX_BURST));
  assign ptr_next    = (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
  assign owned       = (state == ST_OWN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= '0;
      beat_cnt   <= '0;
      rr_ptr     <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      grant_id   <= '0;
    end else begin
      rf_wr_en <= xfer;
      if (xfer) begin
        rf_wr_addr <= req_addr[sel_idx*ADDR_W +: ADDR_W];
        rf_wr_data <= req_data[sel_idx*DATA_W +: DATA_W];
        grant_id   <= sel_idx;
        if (release_now) begin
          state    <= ST_IDLE;
          beat_cnt <= '0;
          rr_ptr   <= ptr_next;
        end else begin
          state    <= ST_OWN;
          owner    <= sel_idx;
          beat_cnt <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - randomized bench for regfile_wr_arbiter against a behavioural model
module tb_regfile_wr_arbiter;

  localparam int N  = 3;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              rf_wr_en;
  logic [AW-1:0]     rf_wr_addr;
  logic [DW-1:0]     rf_wr_data;
  logic [1:0]        grant_id;
  logic              owned;

  regfile_wr_arbiter #(
    .N_REQ     (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .grant_id   (grant_id),
    .owned      (owned)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // requester-side stimulus state
  logic [N-1:0]  vv;
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];
  int            rem [N];
  bit            single_mode;

  // reference model state
  int            m_owner;
  int            m_beats;
  int            m_ptr;
  logic [N-1:0]  exp_r;
  logic [N-1:0]  xfer_prev;
  logic          exp_en;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [1:0]    exp_gid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive();
    req_valid = vv;
    for (int i = 0; i < N; i++) begin
      req_last[i]          = (rem[i] == 1);
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
  endtask

  task automatic new_beat(input int i);
    if (rem[i] == 0) rem[i] = single_mode ? 1 : int'($urandom_range(1, 6));
    a[i]  = AW'($urandom);
    d[i]  = DW'($urandom);
    vv[i] = 1'b1;
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_beats   = 0;
    m_ptr     = 0;
    xfer_prev = '0;
    exp_en    = 1'b0;
    exp_addr  = '0;
    exp_data  = '0;
    exp_gid   = '0;
  endtask

  // Called at a falling edge: check last edge's outputs, advance stimulus, predict this edge.
  task automatic step();
    int  g;
    bit  found;
    chk("wr_en", rf_wr_en, exp_en);
    chk("wr_addr", rf_wr_addr, exp_addr);
    chk("wr_data", rf_wr_data, exp_data);
    chk("grant_id", grant_id, exp_gid);
    chk("owned", owned, m_owner >= 0);
    for (int i = 0; i < N; i++) begin
      if (xfer_prev[i]) begin
        rem[i]--;
        vv[i] = 1'b0;
        if (single_mode || $urandom_range(0, 3) != 0) new_beat(i);
      end else if (!vv[i] && $urandom_range(0, 1) == 1) begin
        new_beat(i);
      end
    end
    drive();
    #1;
    exp_r = '0;
    g     = 0;
    found = 1'b0;
    if (m_owner >= 0) begin
      if (vv[m_owner]) begin
        exp_r[m_owner] = 1'b1;
        g              = m_owner;
        found          = 1'b1;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!found && vv[(m_ptr + k) % N]) begin
          g        = (m_ptr + k) % N;
          exp_r[g] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    chk("ready", req_ready, exp_r);
    xfer_prev = exp_r;
    exp_en    = found;
    if (found) begin
      exp_addr = a[g];
      exp_data = d[g];
      exp_gid  = 2'(g);
      m_beats  = ((m_owner >= 0) ? m_beats : 0) + 1;
      if (rem[g] == 1 || m_beats == MB) begin
        m_owner = -1;
        m_beats = 0;
        m_ptr   = (g + 1) % N;
      end else begin
        m_owner = g;
      end
    end
  endtask

  initial begin
    bit found;
    rst_n       = 1'b0;
    single_mode = 1'b0;
    vv          = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      a[i]   = '0;
      d[i]   = '0;
    end
    drive();
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_addr", rf_wr_addr, 0);
    chk("rst_data", rf_wr_data, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_owned", owned, 0);
    rst_n = 1'b1;
    step();
    repeat (400) begin
      @(negedge clk);
      step();
    end

    single_mode = 1'b1;
    repeat (60) begin
      @(negedge clk);
      step();
    end
    single_mode = 1'b0;

    found = 1'b0;
    for (int t = 0; t < 300 && !found; t++) begin
      @(negedge clk);
      step();
      if (m_owner >= 0 && exp_en) found = 1'b1;
    end
    chk("rst_burst_found", found, 1);
    if (found) begin
      @(posedge clk);
      #1;
      chk("pre_rst_wr_en", rf_wr_en, 1);
      chk("pre_rst_owned", owned, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_wr_en", rf_wr_en, 0);
      chk("midrst_owned", owned, 0);
      chk("midrst_ready", req_ready, 0);
      model_reset();
      for (int i = 0; i < N; i++) begin
        rem[i] = 0;
        new_beat(i);
      end
      drive();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_rst_first", req_ready, 3'b001);
    end

    repeat (200) begin
      @(negedge clk);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
